// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: owns the PC, fetches from combinational instruction memory into a small FIFO for decode.
// Optional macro INST_FETCH_PERF_EN adds perf_fetch_cnt / perf_bp_cnt counters.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_ce,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_err
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bp_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0]   pc_q, pc_d;
  logic          err_lock_q, err_lock_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [DEPTH-1:0] err_mem_q;
  logic aligned, push, pop;
  // A misaligned PC still occupies a slot, as an error marker instead of a fetch
  always_comb begin
    aligned    = pc_q[1:0] == 2'b00;
    push       = rst & ~stall & ~redirect_en & ~err_lock_q & (count_q < FULL);
    inst_ce    = push & aligned;
    inst_addr  = pc_q;
    id_valid   = (count_q != '0) & ~redirect_en;
    pop        = id_valid & id_ready;
    id_inst    = id_valid ? inst_mem_q[head_q] : '0;
    id_pc      = id_valid ? pc_mem_q[head_q] : '0;
    id_err     = id_valid ? err_mem_q[head_q] : 1'b0;
    pc_d       = redirect_en ? redirect_pc : (inst_ce ? pc_q + 32'd4 : pc_q);
    err_lock_d = redirect_en ? 1'b0 : (err_lock_q | (push & ~aligned));
    count_d    = redirect_en ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    head_d     = redirect_en ? '0 : head_q + AW'(pop);
    tail_d     = redirect_en ? '0 : tail_q + AW'(push);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      err_lock_q <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      err_lock_q <= err_lock_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]   <= pc_q;
      inst_mem_q[tail_q] <= aligned ? inst_data : '0;
      err_mem_q[tail_q]  <= ~aligned;
    end
  end
`ifdef INST_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d, perf_bp_q, perf_bp_d;
  always_comb begin
    perf_fetch_d   = perf_fetch_q + 32'(push);
    perf_bp_d      = perf_bp_q + 32'(id_valid & ~id_ready);
    perf_fetch_cnt = perf_fetch_q;
    perf_bp_cnt    = perf_bp_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_bp_q    <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_bp_q    <= perf_bp_d;
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed plus random stimulus against a queue-based fetch model.
module tb_inst_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, stall, redirect_en, id_ready;
  logic [31:0] redirect_pc;
  logic inst_ce, id_valid, id_err;
  logic [31:0] inst_addr, inst_data, id_inst, id_pc;
  logic [31:0] mem [64];
  assign inst_data = mem[inst_addr[7:2]];
`ifdef INST_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_bp_cnt;
`endif
  inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inst_ce(inst_ce), .inst_addr(inst_addr), .inst_data(inst_data),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_err(id_err)
`ifdef INST_FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bp_cnt(perf_bp_cnt)
`endif
  );
  typedef struct packed {logic [31:0] pc; logic [31:0] inst; logic err;} ent_t;
  ent_t q[$];
  logic [31:0] m_pc, m_fetch, m_bp;
  bit m_lock;
  int passes = 0, total = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic model_reset();
    q.delete();
    m_pc = RESET_PC;
    m_lock = 0;
    m_fetch = 0;
    m_bp = 0;
  endtask
  // Check outputs mid-cycle against the model, then advance the model across the edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bit can, ce, v;
      ent_t h;
      #3;
      can = rst && !stall && !redirect_en && !m_lock && q.size() < DEPTH;
      ce  = can && m_pc[1:0] == 2'b00;
      v   = q.size() != 0 && !redirect_en;
      h   = v ? q[0] : '0;
      chk("inst_ce", inst_ce, ce);
      chk("inst_addr", inst_addr, m_pc);
      chk("id_valid", id_valid, v);
      chk("id_pc", id_pc, h.pc);
      chk("id_inst", id_inst, h.inst);
      chk("id_err", id_err, h.err);
`ifdef INST_FETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, m_fetch);
      chk("perf_bp", perf_bp_cnt, m_bp);
`endif
      if (!rst) model_reset();
      else if (redirect_en) begin
        q.delete();
        m_pc = redirect_pc;
        m_lock = 0;
      end else begin
        if (v && !id_ready) m_bp++;
        if (v && id_ready) void'(q.pop_front());
        if (can) begin
          m_fetch++;
          if (ce) begin
            q.push_back('{pc: m_pc, inst: mem[m_pc[7:2]], err: 1'b0});
            m_pc += 32'd4;
          end else begin
            q.push_back('{pc: m_pc, inst: 32'h0, err: 1'b1});
            m_lock = 1;
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic redir(input logic [31:0] tgt);
    redirect_en = 1'b1;
    redirect_pc = tgt;
    tick(1);
    redirect_en = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0000f025;
    mem[1] = 32'h241d1000;
    mem[2] = 32'h8f990008;
    rst = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    tick(2);
    // 1: straight-line fetch after reset
    rst = 1'b1;
    #1 chk("p1_ce", inst_ce, 1'b1);
    chk("p1_addr", inst_addr, 32'h0);
    tick(1);
    #1 chk("p1_beat0", id_inst, 32'h0000f025);
    tick(4);
    // 2: backpressure fills the FIFO
    rst = 1'b0;
    tick(1);
    rst = 1'b1; id_ready = 1'b0;
    tick(6);
    #1 chk("p2_pc", inst_addr, 32'h8);
    chk("p2_ce", inst_ce, 1'b0);
    id_ready = 1'b1;
    tick(4);
    // 3: redirect while full
    id_ready = 1'b0;
    tick(3);
    redirect_en = 1'b1; redirect_pc = 32'h20;
    #1 chk("p3_valid_redir", id_valid, 1'b0);
    tick(1);
    redirect_en = 1'b0;
    #1 chk("p3_addr", inst_addr, 32'h20);
    id_ready = 1'b1;
    tick(1);
    #1 chk("p3_beat_pc", id_pc, 32'h20);
    chk("p3_beat_inst", id_inst, mem[8]);
    tick(2);
    // 4: misaligned target
    redir(32'h22);
    tick(1);
    #1 chk("p4_err", id_err, 1'b1);
    chk("p4_pc", id_pc, 32'h22);
    chk("p4_inst", id_inst, 32'h0);
    tick(5);
    #1 chk("p4_ce_locked", inst_ce, 1'b0);
    redir(32'h88);
    tick(1);
    #1 chk("p4_resume", id_pc, 32'h88);
    tick(1);
    // 5: PC wrap and stall drain
    redir(32'hFFFF_FFFC);
    tick(1);
    #1 chk("p5_top", id_pc, 32'hFFFF_FFFC);
    tick(1);
    #1 chk("p5_wrap", id_pc, 32'h0);
    tick(2);
    stall = 1'b1;
    tick(3);
    #1 chk("p5_drained", id_valid, 1'b0);
    chk("p5_ce", inst_ce, 1'b0);
    chk("p5_pc", inst_addr, 32'hC);
    stall = 1'b0;
    // 6: reset with a full FIFO
    id_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    #1 chk("p6_valid", id_valid, 1'b0);
    chk("p6_pc", id_pc, 32'h0);
    chk("p6_inst", id_inst, 32'h0);
    chk("p6_err", id_err, 1'b0);
`ifdef INST_FETCH_PERF_EN
    chk("p6_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("p6_perf_bp", perf_bp_cnt, 32'h0);
`endif
    rst = 1'b1; id_ready = 1'b1;
    tick(1);
    #1 chk("p6_first", id_pc, RESET_PC);
    chk("p6_first_v", id_valid, 1'b1);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] t;
      rst = $urandom_range(0, 99) != 0;
      stall = $urandom_range(0, 3) == 0;
      id_ready = $urandom_range(0, 4) < 3;
      redirect_en = $urandom_range(0, 11) == 0;
      t = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 4) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      redirect_pc = t;
      tick(1);
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch initiator for the MIPS core: owns the PC and drives ce/addr of the combinational instruction memory.
- Captures the returned word together with its PC in a small FIFO and presents it to decode over a valid/ready handshake.
- Handles branch/jump redirect with flush, stall and misaligned-target detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
inst_ce  output  1  instruction memory chip enable
inst_addr  output  32  byte address to instruction memory (= pc)
inst_data  input  32  instruction word, valid combinationally in the same cycle as inst_ce/inst_addr
stall  input  1  1 = do not issue new fetches
redirect_en  input  1  1-cycle pulse, branch/jump taken
redirect_pc  input  32  redirect target
id_valid  output  1  head entry valid toward decode
id_ready  input  1  decode accepts head entry
id_inst  output  32  head instruction, 0 when id_valid=0
id_pc  output  32  head PC, 0 when id_valid=0
id_err  output  1  head entry is an address-error (misaligned PC) marker

Behaviour:
- Reset (rst=0 at clk edge):
  - pc=RESET_PC; FIFO count=0; err_lock=0.
  - Outputs: inst_ce=0, id_valid=0, id_inst=0, id_pc=0, id_err=0.
- inst_addr=pc at all times.
- Combinational outputs:
  - inst_ce = rst & !stall & !redirect_en & !err_lock & (pc[1:0]==0) & (count<DEPTH).
  - id_valid = (count!=0) & !redirect_en.
- Push (inst_ce=1), at the edge:
  - Write {pc, inst_data, err=0} at the tail.
  - pc<=pc+4, modulo 2^32 (0xFFFFFFFC -> 0x0).
- Misaligned pc (pc[1:0]!=0), with rst & !stall & !redirect_en & !err_lock & count<DEPTH:
  - Push {pc, 32'h0, err=1} with inst_ce=0.
  - Set err_lock=1; pc holds.
  - No further pushes until the next redirect.
- Pop: at an edge where id_valid & id_ready, advance the head.
- Simultaneous push and pop are both honoured.
- When full (count==DEPTH), no push occurs even if a pop happens that cycle; there is no bypass.
- Latency: an entry pushed at edge N is visible on id_* after edge N (one cycle from inst_ce to id_valid).
- Redirect (highest priority over push/pop), at the edge:
  - count<=0; pc<=redirect_pc; err_lock<=0.
  - No handshake completes in the redirect cycle, because id_valid is forced 0.
- Delay-slot contract: the pipeline issues redirect only after the delay-slot instruction has been accepted. The unit drops everything buffered.
- stall: blocks pushes only; pops continue, so the FIFO drains.
- Reset mid-operation discards all entries; the cycle after reset release fetches RESET_PC.
- Order is strictly preserved; no entry is ever duplicated or dropped except by redirect or reset.

Optional Feature:
- Macro INST_FETCH_PERF_EN.
- Defined: adds two outputs.
  - perf_fetch_cnt (32): increments on each push, including error markers.
  - perf_bp_cnt (32): increments each cycle with id_valid & !id_ready.
  - Both counters clear on reset, wrap at 2^32, and are unaffected by redirect.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
1. Reset then rst=1, id_ready=1, memory word0=0x0000f025, word1=0x241d1000, word2=0x8f990008.
   -> inst_ce=1 with inst_addr=0 in the first cycle after reset release.
   -> id beats (pc, inst) = (0, 0x0000f025), (4, 0x241d1000), (8, 0x8f990008) on consecutive cycles, starting one cycle later.
2. id_ready=0 for 6 cycles after reset.
   -> exactly 2 pushes; inst_ce=0 thereafter; pc=8.
   -> After id_ready=1, beats arrive in order pc 0, 4, 8, with no gap larger than one cycle.
3. FIFO full, redirect_en pulse with redirect_pc=0x20.
   -> id_valid=0 in that cycle.
   -> Next cycle inst_addr=0x20; next beat is pc=0x20, inst=memory word 8; old entries are never presented.
4. Redirect to 0x22.
   -> One beat with id_err=1, id_pc=0x22, id_inst=0.
   -> inst_ce stays 0 indefinitely.
   -> Redirect to 0x88 resumes with beat pc=0x88.
5. Redirect to 0xFFFFFFFC with stall=0.
   -> Beats pc 0xFFFFFFFC then 0x00000000.
   -> Separately, stall=1 for 3 cycles with id_ready=1: the FIFO drains, inst_ce=0, and pc is unchanged.
6. rst=0 for one edge while the FIFO holds 2 entries.
   -> id_valid=0 and id_inst/id_pc/id_err=0 after that edge.
   -> The first beat after release has pc=RESET_PC.
   -> With INST_FETCH_PERF_EN, both counters read 0.
